// File: rtl/infer_pkg.sv
// Shared definitions for the inference job scheduler and its accelerator benches:
// FSM state encoding, result width and default watchdog limits.
package infer_pkg;

  localparam int RES_W       = 4;
  localparam int TIMEOUT_DEF = 512;
  localparam int CNT_W_DEF   = 10;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT1 = 3'd2;
  localparam logic [2:0] S_WAIT2 = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    ISSUE = S_ISSUE,
    WAIT1 = S_WAIT1,
    WAIT2 = S_WAIT2,
    DONE  = S_DONE
  } state_e;

endpackage

// File: rtl/infer_job_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: grants a sole requester directly, otherwise the
// pointer picks; the pointer flips only when a contended grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_i && (req_i == 2'b11)) begin
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/infer_job_scheduler.sv
// Schedules inference jobs from two requesters onto one accelerator, pairing
// two 4-bit images into a single split run when both are eligible.
module infer_job_scheduler
  import infer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       req_lowp,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [RES_W-1:0] result,
  output logic             err,
  output logic             acc_start,
  output logic             acc_split,
  input  logic             acc_valid,
  input  logic [RES_W-1:0] acc_result,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             paired_q, paired_d;
  logic             phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] res0_q, res0_d;
  logic [RES_W-1:0] res1_q, res1_d;
  logic             err0_q, err0_d;
  logic             err1_q, err1_d;

  logic [1:0] arb_gnt;
  logic       arb_update;
  logic       pair_req;

  assign pair_req = (req == 2'b11) && (req_lowp == 2'b11);

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req),
    .update_i (arb_update),
    .gnt_o    (arb_gnt)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    paired_d   = paired_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    res0_d     = res0_q;
    res1_d     = res1_q;
    err0_d     = err0_q;
    err1_d     = err1_q;
    arb_update = 1'b0;

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          res0_d  = '0;
          res1_d  = '0;
          err0_d  = 1'b0;
          err1_d  = 1'b0;
          phase_d = 1'b0;
          if (pair_req) begin
            gnt_d    = 2'b11;
            paired_d = 1'b1;
          end else begin
            gnt_d      = arb_gnt;
            paired_d   = 1'b0;
            arb_update = 1'b1;
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT1;
      end

      // Timeout leaves results at zero; only error flags are raised.
      WAIT1: begin
        if (acc_valid) begin
          res0_d  = acc_result;
          cnt_d   = '0;
          state_d = paired_q ? WAIT2 : DONE;
        end else if (cnt_q == TMO_LAST) begin
          err0_d  = 1'b1;
          err1_d  = paired_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT2: begin
        if (acc_valid) begin
          res1_d  = acc_result;
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == TMO_LAST) begin
          err1_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Paired jobs stay one extra cycle to report requester 1.
      DONE: begin
        if (paired_q && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          state_d  = IDLE;
          gnt_d    = 2'b00;
          paired_d = 1'b0;
          phase_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      paired_q <= 1'b0;
      phase_q  <= 1'b0;
      cnt_q    <= '0;
      res0_q   <= '0;
      res1_q   <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      paired_q <= paired_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      res0_q   <= res0_d;
      res1_q   <= res1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  always_comb begin
    done   = 2'b00;
    result = '0;
    err    = 1'b0;
    if (state_q == DONE) begin
      if (paired_q && phase_q) begin
        done   = 2'b10;
        result = res1_q;
        err    = err1_q;
      end else if (paired_q) begin
        done   = 2'b01;
        result = res0_q;
        err    = err0_q;
      end else begin
        done   = gnt_q;
        result = res0_q;
        err    = err0_q;
      end
    end
  end

  assign gnt       = gnt_q;
  assign acc_start = (state_q == ISSUE);
  assign acc_split = acc_start & paired_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_infer_job_scheduler.sv
// Randomized scoreboard bench for infer_job_scheduler with a behavioural
// requester/accelerator model and directed corner cases.
module tb_infer_job_scheduler;
  import infer_pkg::*;

  localparam int TMO = 512;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req = 2'b00;
  logic [1:0]       req_lowp = 2'b00;
  logic             acc_valid = 1'b0;
  logic [RES_W-1:0] acc_result = '0;
  logic [1:0]       gnt, done;
  logic [RES_W-1:0] result;
  logic             err, acc_start, acc_split, busy;

  infer_job_scheduler #(.TIMEOUT(TMO), .CNT_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_lowp(req_lowp),
    .gnt(gnt), .done(done), .result(result), .err(err),
    .acc_start(acc_start), .acc_split(acc_split),
    .acc_valid(acc_valid), .acc_result(acc_result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { int d1; logic [3:0] r1; int d2; logic [3:0] r2; } plan_t;
  typedef struct packed { logic [1:0] g; logic split; } job_t;
  typedef struct packed { logic [1:0] dn; logic [3:0] res; logic er; int lat; } exp_t;

  plan_t plan_q[$];
  plan_t fixed_q[$];
  job_t  job_q[$];
  exp_t  exp_q[$];

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_evt = 0;
  logic [1:0] done_seen = 2'b00;
  logic       model_rr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual %0h required %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int rnd_delay();
    return ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
  endfunction

  // Expected outcome of one job, from the accelerator plan it will see.
  task automatic add_job(input logic [1:0] g, input logic split);
    plan_t p;
    if (fixed_q.size() != 0) begin
      p = fixed_q.pop_front();
    end else begin
      p.d1 = rnd_delay();
      p.r1 = 4'($urandom_range(0, 15));
      p.d2 = rnd_delay();
      p.r2 = 4'($urandom_range(0, 15));
    end
    plan_q.push_back(p);
    job_q.push_back('{g: g, split: split});
    if (!split) begin
      if (p.d1 != 0) exp_q.push_back('{dn: g, res: p.r1, er: 1'b0, lat: 1});
      else           exp_q.push_back('{dn: g, res: 4'h0, er: 1'b1, lat: TMO + 1});
    end else if (p.d1 == 0) begin
      exp_q.push_back('{dn: 2'b01, res: 4'h0, er: 1'b1, lat: TMO + 1});
      exp_q.push_back('{dn: 2'b10, res: 4'h0, er: 1'b1, lat: TMO + 2});
    end else if (p.d2 == 0) begin
      exp_q.push_back('{dn: 2'b01, res: p.r1, er: 1'b0, lat: TMO + 1});
      exp_q.push_back('{dn: 2'b10, res: 4'h0, er: 1'b1, lat: TMO + 2});
    end else begin
      exp_q.push_back('{dn: 2'b01, res: p.r1, er: 1'b0, lat: 1});
      exp_q.push_back('{dn: 2'b10, res: p.r2, er: 1'b0, lat: 2});
    end
  endtask

  task automatic model_round(input logic [1:0] rq, input logic [1:0] lp, input int hold);
    logic [1:0] pend;
    logic [1:0] oh;
    pend = rq;
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        oh = model_rr ? 2'b10 : 2'b01;
        model_rr = ~model_rr;
        add_job(oh, 1'b0);
      end
    end else begin
      while (pend != 2'b00) begin
        if (pend == 2'b11 && lp == 2'b11) begin
          add_job(2'b11, 1'b1);
          pend = 2'b00;
        end else begin
          if (pend == 2'b11) begin
            oh = model_rr ? 2'b10 : 2'b01;
            model_rr = ~model_rr;
          end else begin
            oh = pend;
          end
          add_job(oh, 1'b0);
          pend = pend & ~oh;
        end
      end
    end
  endtask

  // Requesters hold req until their own done (or until `hold` jobs complete).
  task automatic drive_round(input logic [1:0] rq, input logic [1:0] lp, input int hold);
    int hcnt;
    hcnt = 0;
    model_round(rq, lp, hold);
    @(posedge clk); #1;
    req = rq;
    req_lowp = lp;
    for (int c = 0; c < 5000 && req != 2'b00; c++) begin
      @(posedge clk); #1;
      if (done_seen != 2'b00) begin
        if (hold == 0) begin
          req = req & ~done_seen;
        end else begin
          hcnt++;
          if (hcnt == hold) req = 2'b00;
        end
      end
    end
    chk("round_completed", {30'd0, req}, 32'd0);
    req = 2'b00;
    req_lowp = 2'b00;
  endtask

  task automatic pulse(input int d, input logic [3:0] r);
    repeat (d - 1) begin @(posedge clk); #1; end
    acc_valid = 1'b1;
    acc_result = r;
    @(posedge clk); #1;
    acc_valid = 1'b0;
    acc_result = '0;
  endtask

  // Accelerator model: answers each acc_start according to the next plan.
  initial begin
    plan_t p;
    logic  sp;
    forever begin
      @(negedge clk);
      if (rst_n && acc_start && plan_q.size() != 0) begin
        p = plan_q.pop_front();
        sp = acc_split;
        @(posedge clk); #1;
        if (p.d1 != 0) begin
          pulse(p.d1, p.r1);
          if (sp && p.d2 != 0) pulse(p.d2, p.r2);
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    job_t j;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      done_seen = rst_n ? done : 2'b00;
      if (!rst_n) begin
        chk("reset_outputs_zero", {20'd0, gnt, done, result, err, acc_start, acc_split, busy}, 32'd0);
      end else begin
        if (done != 2'b00) begin
          chk("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("done_vector", {30'd0, done}, {30'd0, e.dn});
            chk("done_result", {28'd0, result}, {28'd0, e.res});
            chk("done_err", {31'd0, err}, {31'd0, e.er});
            chk("done_latency", cyc - last_evt, e.lat);
            chk("gnt_covers_done", {30'd0, gnt & done}, {30'd0, done});
          end
        end else begin
          chk("idle_result_err_zero", {27'd0, result, err}, 32'd0);
        end
        if (acc_start) begin
          last_evt = cyc;
          chk("start_expected", {31'd0, job_q.size() != 0}, 32'd1);
          if (job_q.size() != 0) begin
            j = job_q.pop_front();
            chk("start_gnt", {30'd0, gnt}, {30'd0, j.g});
            chk("start_split", {31'd0, acc_split}, {31'd0, j.split});
          end
        end
        if (acc_valid) last_evt = cyc;
      end
    end
  end

  // Stimulus.
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    fixed_q.push_back('{d1: 120, r1: 4'h7, d2: 0, r2: 4'h0});
    drive_round(2'b01, 2'b00, 0);

    fixed_q.push_back('{d1: int'($urandom_range(1, 20)), r1: 4'h3, d2: int'($urandom_range(1, 20)), r2: 4'h9});
    drive_round(2'b11, 2'b11, 0);

    for (int k = 0; k < 4; k++) fixed_q.push_back('{d1: int'($urandom_range(1, 30)), r1: 4'(k + 1), d2: 0, r2: 4'h0});
    drive_round(2'b11, 2'b01, 4);

    fixed_q.push_back('{d1: 0, r1: 4'h0, d2: 0, r2: 4'h0});
    drive_round(2'b10, 2'b00, 0);

    fixed_q.push_back('{d1: 5, r1: 4'hA, d2: 0, r2: 4'h0});
    drive_round(2'b11, 2'b11, 0);

    fixed_q.push_back('{d1: 0, r1: 4'h0, d2: 0, r2: 4'h0});
    drive_round(2'b11, 2'b11, 0);

    // Reset while a paired job waits for its second result.
    plan_q.push_back('{d1: 3, r1: 4'h5, d2: 30, r2: 4'h6});
    job_q.push_back('{g: 2'b11, split: 1'b1});
    @(posedge clk); #1;
    req = 2'b11;
    req_lowp = 2'b11;
    repeat (6) @(posedge clk);
    #1;
    chk("busy_before_reset", {31'd0, busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_gnt", {30'd0, gnt}, 32'd0);
    @(posedge clk); #1;
    req = 2'b00;
    req_lowp = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    model_rr = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("late_valid_ignored", {31'd0, busy}, 32'd0);

    drive_round(2'b01, 2'b00, 0);

    for (int r = 0; r < 40; r++) begin
      drive_round(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 0);
    end

    repeat (20) @(posedge clk);
    chk("exp_queue_drained", exp_q.size(), 32'd0);
    chk("job_queue_drained", job_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
